apb_timer_slave: RTL and testbench

- APB completer (responder) peripheral: a 4-register programmable down-counter timer with optional auto-reload and an interrupt output.
- Sits on the APB side that apb_master drives, as a sibling of apb_slave, and is driven by the same PADDR/PSEL/PENABLE/PWRITE/PWDATA bus.
- Adds a configurable number of wait states and returns PSLVERR for illegal accesses.

---
 rtl/apb_timer_slave.sv | 175 +++++++++++++++++
 tb/tb_apb_timer_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB completer with a 4-register programmable down-counter timer.
// Supports auto-reload, a level interrupt, configurable wait states and PSLVERR on illegal accesses.
module apb_timer_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  irq
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state, state_next;
    logic [3:0]            wcnt, wcnt_next;

    logic                  en, auto_rl, irq_en, expired;
    logic [DATA_WIDTH-1:0] load_val, count;
    logic                  en_n, auto_n, ie_n, exp_n;
    logic [DATA_WIDTH-1:0] load_n, count_n;
    logic                  expire;

    logic                  illegal;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] rd_mux, resp_data;
    logic                  resp_err;
    logic                  wr_en;
    logic                  unused_addr;

    assign idx         = PADDR[3:2];
    assign unused_addr = &{1'b0, PADDR[1:0]};

    generate
        if (ADDR_WIDTH > 4) begin : g_hi_addr
            assign illegal = |PADDR[ADDR_WIDTH-1:4];
        end else begin : g_no_hi_addr
            assign illegal = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        case (state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                        wcnt_next  = 4'(WAIT_STATES - 1);
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_next = S_IDLE;
                end else if (wcnt == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    wcnt_next = wcnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Response is decoded from the bus and registers one cycle ahead of RESP.
    always_comb begin
        rd_mux = '0;
        case (idx)
            2'd0: rd_mux = {{(DATA_WIDTH-3){1'b0}}, irq_en, auto_rl, en};
            2'd1: rd_mux = load_val;
            2'd2: rd_mux = count;
            2'd3: rd_mux = {{(DATA_WIDTH-1){1'b0}}, expired};
            default: rd_mux = '0;
        endcase
        resp_err  = illegal || (PWRITE && (idx == 2'd2));
        resp_data = (illegal || PWRITE) ? '0 : rd_mux;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            PREADY <= (state_next == S_RESP);
            if (state_next == S_RESP) begin
                PSLVERR <= resp_err;
                PRDATA  <= resp_data;
            end
        end
    end

    assign wr_en = (state == S_RESP) && PSEL && PENABLE && PWRITE && !illegal;

    // Counter update first, then bus writes override; expiry overrides the W1C clear.
    always_comb begin
        en_n    = en;
        auto_n  = auto_rl;
        ie_n    = irq_en;
        load_n  = load_val;
        count_n = count;
        exp_n   = expired;
        expire  = 1'b0;
        if (en) begin
            if (count != '0) begin
                count_n = count - DATA_WIDTH'(1);
            end else begin
                expire = 1'b1;
                if (auto_rl) begin
                    count_n = load_val;
                end else begin
                    en_n = 1'b0;
                end
            end
        end
        if (wr_en) begin
            case (idx)
                2'd0: {ie_n, auto_n, en_n} = PWDATA[2:0];
                2'd1: begin
                    load_n  = PWDATA;
                    count_n = PWDATA;
                end
                2'd3: if (PWDATA[0]) exp_n = 1'b0;
                default: ;
            endcase
        end
        if (expire) begin
            exp_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            irq_en   <= 1'b0;
            load_val <= '0;
            count    <= '0;
            expired  <= 1'b0;
        end else begin
            en       <= en_n;
            auto_rl  <= auto_n;
            irq_en   <= ie_n;
            load_val <= load_n;
            count    <= count_n;
            expired  <= exp_n;
        end
    end

    assign irq = expired & irq_en;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: one instance with no wait states, one with three.
// Expected responses are queued when a transfer starts and compared when PREADY rises.
module tb_apb_timer_slave;

    logic        clk;
    logic        rst;
    logic [31:0] paddr;
    logic        psel0, psel3;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready0, pslverr0, irq0;
    logic        pready3, pslverr3, irq3;
    logic [31:0] prdata0, prdata3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];

    apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready0), .PSLVERR(pslverr0),
        .PRDATA(prdata0), .irq(irq0)
    );

    apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .PADDR(paddr), .PSEL(psel3), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready3), .PSLVERR(pslverr3),
        .PRDATA(prdata3), .irq(irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full APB transfer starting in the current cycle (called just after a clock edge).
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
        exp_t e;
        exp_t g;
        int   cyc;
        logic rdy;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = (d == 3) ? 4 : 1;
        e.tag   = tag;
        sb.push_back(e);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        penable = 1'b0;
        if (d == 3) psel3 = 1'b1;
        else        psel0 = 1'b1;
        @(posedge clk) #1;
        penable = 1'b1;
        cyc = 1;
        rdy = (d == 3) ? pready3 : pready0;
        while (!rdy && cyc < 20) begin
            @(posedge clk) #1;
            cyc++;
            rdy = (d == 3) ? pready3 : pready0;
        end
        g = sb.pop_front();
        check({g.tag, ".cyc"}, 32'(cyc), 32'(g.cyc));
        check({g.tag, ".rdata"}, (d == 3) ? prdata3 : prdata0, g.rdata);
        check({g.tag, ".err"}, {31'd0, (d == 3) ? pslverr3 : pslverr0}, {31'd0, g.err});
        @(posedge clk) #1;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        check({g.tag, ".ready_low"}, {31'd0, (d == 3) ? pready3 : pready0}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; paddr = '0; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.pready0", {31'd0, pready0}, 32'd0);
        check("rst.prdata0", prdata0, 32'd0);
        check("rst.irq0", {31'd0, irq0}, 32'd0);
        check("rst.pready3", {31'd0, pready3}, 32'd0);
        rst = 1'b0;
        @(posedge clk) #1;

        // Reset values of all registers
        xfer(0, 0, 32'h0, 0, 32'h0, 0, "t1.ctrl");
        xfer(0, 0, 32'h4, 0, 32'h0, 0, "t1.load");
        xfer(0, 0, 32'h8, 0, 32'h0, 0, "t1.count");
        xfer(0, 0, 32'hC, 0, 32'h0, 0, "t1.status");
        check("t1.irq", {31'd0, irq0}, 32'd0);

        // Auto-reload countdown, period LOAD+1
        xfer(0, 1, 32'h4, 32'd3, 32'h0, 0, "t2.wload");
        xfer(0, 1, 32'h0, 32'h7, 32'h0, 0, "t2.wctrl");
        xfer(0, 0, 32'h8, 0, 32'd3, 0, "t2.count3");
        xfer(0, 0, 32'h8, 0, 32'd1, 0, "t2.count1");
        check("t2.irq_set", {31'd0, irq0}, 32'd1);
        xfer(0, 0, 32'h8, 0, 32'd3, 0, "t2.reload");
        xfer(0, 0, 32'hC, 0, 32'd1, 0, "t2.status");
        repeat (3) @(posedge clk);
        #1;
        xfer(0, 0, 32'h8, 0, 32'd0, 0, "t2.count0");
        xfer(0, 1, 32'h0, 32'h0, 32'h0, 0, "t2.stop");
        xfer(0, 1, 32'hC, 32'h1, 32'h0, 0, "t2.w1c");
        xfer(0, 0, 32'hC, 0, 32'd0, 0, "t2.cleared");
        check("t2.irq_clr", {31'd0, irq0}, 32'd0);

        // One-shot: EN self-clears, COUNT holds 0
        xfer(0, 1, 32'h4, 32'd2, 32'h0, 0, "t3.wload");
        xfer(0, 1, 32'h0, 32'h1, 32'h0, 0, "t3.wctrl");
        repeat (4) @(posedge clk);
        #1;
        xfer(0, 0, 32'h0, 0, 32'h0, 0, "t3.ctrl");
        xfer(0, 0, 32'h8, 0, 32'h0, 0, "t3.count");
        xfer(0, 0, 32'hC, 0, 32'h1, 0, "t3.status");
        check("t3.irq_masked", {31'd0, irq0}, 32'd0);
        xfer(0, 1, 32'hC, 32'h1, 32'h0, 0, "t3.w1c");
        xfer(0, 0, 32'hC, 0, 32'h0, 0, "t3.cleared");

        // Error responses
        xfer(0, 1, 32'h8, 32'h55, 32'h0, 1, "t4.wcount");
        xfer(0, 1, 32'h10, 32'h7, 32'h0, 1, "t4.w10");
        xfer(0, 0, 32'h10, 0, 32'h0, 1, "t4.r10");
        xfer(0, 0, 32'h14, 0, 32'h0, 1, "t4.r14");
        xfer(0, 0, 32'h8, 0, 32'h0, 0, "t4.count");
        xfer(0, 0, 32'h4, 0, 32'd2, 0, "t4.load");
        xfer(0, 0, 32'h0, 0, 32'h0, 0, "t4.ctrl");

        // Expiry on the same edge as a W1C clear
        xfer(0, 1, 32'h4, 32'd1, 32'h0, 0, "t6.wload1");
        xfer(0, 1, 32'h0, 32'h7, 32'h0, 0, "t6.wctrl");
        xfer(0, 1, 32'hC, 32'h1, 32'h0, 0, "t6.w1c_race");
        xfer(0, 0, 32'hC, 0, 32'h1, 0, "t6.exp_wins");
        xfer(0, 1, 32'h0, 32'h0, 32'h0, 0, "t6.stop");
        xfer(0, 1, 32'hC, 32'h1, 32'h0, 0, "t6.w1c");
        xfer(0, 0, 32'hC, 0, 32'h0, 0, "t6.cleared");

        // LOAD write on the same edge as a decrement
        xfer(0, 1, 32'h4, 32'd100, 32'h0, 0, "t6.wload100");
        xfer(0, 1, 32'h0, 32'h3, 32'h0, 0, "t6.run");
        xfer(0, 1, 32'h4, 32'h40, 32'h0, 0, "t6.wload40");
        xfer(0, 0, 32'h8, 0, 32'h40, 0, "t6.write_wins");
        xfer(0, 1, 32'h0, 32'h0, 32'h0, 0, "t6.stop2");

        // Wait states and aborted transfer
        xfer(3, 1, 32'h4, 32'h1234, 32'h0, 0, "t5.wload");
        xfer(3, 0, 32'h4, 0, 32'h1234, 0, "t5.rload");
        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hBEEF; penable = 1'b0; psel3 = 1'b1;
        @(posedge clk) #1;
        penable = 1'b1;
        check("t5.abort_acc1", {31'd0, pready3}, 32'd0);
        @(posedge clk) #1;
        psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("t5.abort_acc2", {31'd0, pready3}, 32'd0);
        @(posedge clk) #1;
        check("t5.abort_idle", {31'd0, pready3}, 32'd0);
        xfer(3, 0, 32'h4, 0, 32'h1234, 0, "t5.no_write");

        // Reset in the middle of a wait-stated transfer
        xfer(3, 1, 32'h4, 32'h0, 32'h0, 0, "t6.wload0");
        xfer(3, 1, 32'h0, 32'h5, 32'h0, 0, "t6.wctrl5");
        @(posedge clk) #1;
        check("t6.irq3", {31'd0, irq3}, 32'd1);
        xfer(3, 0, 32'h0, 0, 32'h4, 0, "t6.ctrl_en_cleared");
        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h77; penable = 1'b0; psel3 = 1'b1;
        @(posedge clk) #1;
        penable = 1'b1;
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        check("t6.rst_pready", {31'd0, pready3}, 32'd0);
        check("t6.rst_prdata", prdata3, 32'd0);
        check("t6.rst_pslverr", {31'd0, pslverr3}, 32'd0);
        check("t6.rst_irq", {31'd0, irq3}, 32'd0);
        rst = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk) #1;
        xfer(3, 0, 32'h4, 0, 32'h0, 0, "t6.rst_no_write");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
